// File: rtl/color_box_tracker.sv
// Per-frame bounding box and hit count of colour-matched VGA pixels.
// Optional BOX_OVERLAY_EN draws the last valid box onto the pixel stream.
module color_box_tracker #(
  parameter int          COORD_W   = 11,
  parameter int          CNT_W     = 20,
  parameter int          MIN_HITS  = 64,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic               vga_vs,
  input  logic               vga_de,
  input  logic               pix_hit,
`ifdef BOX_OVERLAY_EN
  input  logic [15:0]        rgb_in,
  output logic [15:0]        rgb_out,
`endif
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               box_valid,
  output logic               box_update
);

  localparam logic [COORD_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0]   N_MAX = '1;
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic [CNT_W-1:0]   N_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   N_MIN = CNT_W'(MIN_HITS);

  logic               vs_q, de_q;
  logic               frame_start, line_end, hit;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] ax0_q, ax0_d, ax1_q, ax1_d;
  logic [COORD_W-1:0] ay0_q, ay0_d, ay1_q, ay1_d;
  logic [CNT_W-1:0]   an_q, an_d;
  logic               started_q, started_d;
  logic [COORD_W-1:0] bx0_q, bx0_d, bx1_q, bx1_d;
  logic [COORD_W-1:0] by0_q, by0_d, by1_q, by1_d;
  logic [CNT_W-1:0]   hc_q, hc_d;
  logic               val_q, val_d, upd_q, upd_d;

  assign frame_start = vs_q & ~vga_vs;
  assign line_end    = de_q & ~vga_de;
  assign hit         = vga_de & pix_hit;

  always_comb begin
    x_d       = '0;
    y_d       = y_q;
    ax0_d     = ax0_q;
    ax1_d     = ax1_q;
    ay0_d     = ay0_q;
    ay1_d     = ay1_q;
    an_d      = an_q;
    started_d = started_q;
    bx0_d     = bx0_q;
    bx1_d     = bx1_q;
    by0_d     = by0_q;
    by1_d     = by1_q;
    hc_d      = hc_q;
    val_d     = val_q;
    upd_d     = 1'b0;
    if (vga_de)
      x_d = (x_q == C_MAX) ? x_q : x_q + C_ONE;
    if (frame_start)
      y_d = '0;
    else if (line_end && y_q != C_MAX)
      y_d = y_q + C_ONE;
    if (frame_start) begin
      if (started_q) begin
        upd_d = 1'b1;
        hc_d  = an_q;
        val_d = (an_q >= N_MIN);
        if (an_q >= N_MIN) begin
          bx0_d = ax0_q;
          bx1_d = ax1_q;
          by0_d = ay0_q;
          by1_d = ay1_q;
        end
      end else begin
        started_d = 1'b1;
      end
      // a hit coinciding with the frame edge is dropped
      ax0_d = C_MAX;
      ax1_d = '0;
      ay0_d = C_MAX;
      ay1_d = '0;
      an_d  = '0;
    end else if (hit) begin
      if (x_q < ax0_q) ax0_d = x_q;
      if (x_q > ax1_q) ax1_d = x_q;
      if (y_q < ay0_q) ay0_d = y_q;
      if (y_q > ay1_q) ay1_d = y_q;
      if (an_q != N_MAX) an_d = an_q + N_ONE;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ax0_q     <= C_MAX;
      ax1_q     <= '0;
      ay0_q     <= C_MAX;
      ay1_q     <= '0;
      an_q      <= '0;
      started_q <= 1'b0;
      bx0_q     <= '0;
      bx1_q     <= '0;
      by0_q     <= '0;
      by1_q     <= '0;
      hc_q      <= '0;
      val_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      vs_q      <= vga_vs;
      de_q      <= vga_de;
      x_q       <= x_d;
      y_q       <= y_d;
      ax0_q     <= ax0_d;
      ax1_q     <= ax1_d;
      ay0_q     <= ay0_d;
      ay1_q     <= ay1_d;
      an_q      <= an_d;
      started_q <= started_d;
      bx0_q     <= bx0_d;
      bx1_q     <= bx1_d;
      by0_q     <= by0_d;
      by1_q     <= by1_d;
      hc_q      <= hc_d;
      val_q     <= val_d;
      upd_q     <= upd_d;
    end
  end

  assign box_x_min  = bx0_q;
  assign box_x_max  = bx1_q;
  assign box_y_min  = by0_q;
  assign box_y_max  = by1_q;
  assign hit_cnt    = hc_q;
  assign box_valid  = val_q;
  assign box_update = upd_q;

`ifdef BOX_OVERLAY_EN
  logic        x_in, y_in, on_edge;
  logic [15:0] rgb_q, rgb_d;

  always_comb begin
    x_in    = (x_q >= bx0_q) && (x_q <= bx1_q);
    y_in    = (y_q >= by0_q) && (y_q <= by1_q);
    on_edge = ((x_q == bx0_q || x_q == bx1_q) && y_in)
           || ((y_q == by0_q || y_q == by1_q) && x_in);
    rgb_d   = (val_q && vga_de && on_edge) ? BOX_COLOR : rgb_in;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rgb_q <= '0;
    else            rgb_q <= rgb_d;
  end

  assign rgb_out = rgb_q;
`endif

endmodule

// File: tb/tb_color_box_tracker.sv
// Bench for color_box_tracker: two instances (MIN_HITS 64 and 1) on one
// stream, checked each cycle against a per-frame bounding-box model.
module tb_color_box_tracker;

  localparam int NONE = 0, RECT = 1, SPARSE = 2, CORNER = 3, OVL = 4;

  logic clk = 1'b0;
  logic rst_n, vga_vs, vga_de, pix_hit;
  logic [10:0] bxmin[2], bxmax[2], bymin[2], bymax[2];
  logic [19:0] hc[2];
  logic        bval[2], bupd[2];

  int thr[2] = '{64, 1};
  int checks = 0, errors = 0;
  int pulses[2] = '{0, 0};

  // model state
  int          m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  bit          m_started;
  logic [10:0] e_xmin[2], e_xmax[2], e_ymin[2], e_ymax[2];
  logic [19:0] e_hc[2];
  logic        e_val[2], e_upd[2];
  int          cur_x = 0, cur_y = 0;
  int          rst_x = -1, rst_y = -1;
  bit          in_ovl = 0;

`ifdef BOX_OVERLAY_EN
  logic [15:0] rgb_in;
  logic [15:0] rgb_out[2];
  logic [15:0] e_rgb[2];
  int          p_x, p_y;
  logic        p_de;
`endif

  always #5 clk = ~clk;

  color_box_tracker #(.MIN_HITS(64)) u64 (
    .vga_clk(clk), .sys_rst_n(rst_n), .vga_vs(vga_vs),
    .vga_de(vga_de), .pix_hit(pix_hit),
`ifdef BOX_OVERLAY_EN
    .rgb_in(rgb_in), .rgb_out(rgb_out[0]),
`endif
    .box_x_min(bxmin[0]), .box_x_max(bxmax[0]),
    .box_y_min(bymin[0]), .box_y_max(bymax[0]),
    .hit_cnt(hc[0]), .box_valid(bval[0]), .box_update(bupd[0]));

  color_box_tracker #(.MIN_HITS(1)) u1 (
    .vga_clk(clk), .sys_rst_n(rst_n), .vga_vs(vga_vs),
    .vga_de(vga_de), .pix_hit(pix_hit),
`ifdef BOX_OVERLAY_EN
    .rgb_in(rgb_in), .rgb_out(rgb_out[1]),
`endif
    .box_x_min(bxmin[1]), .box_x_max(bxmax[1]),
    .box_y_min(bymin[1]), .box_y_max(bymax[1]),
    .hit_cnt(hc[1]), .box_valid(bval[1]), .box_update(bupd[1]));

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_cnt = 0;
    m_xmin = 2047; m_xmax = 0;
    m_ymin = 2047; m_ymax = 0;
  endfunction

  function automatic void model_reset();
    m_started = 0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      e_xmin[i] = '0; e_xmax[i] = '0; e_ymin[i] = '0; e_ymax[i] = '0;
      e_hc[i] = '0; e_val[i] = 1'b0; e_upd[i] = 1'b0;
    end
  endfunction

  function automatic void model_hit(input int x, input int y);
    m_cnt++;
    if (x < m_xmin) m_xmin = x;
    if (x > m_xmax) m_xmax = x;
    if (y < m_ymin) m_ymin = y;
    if (y > m_ymax) m_ymax = y;
  endfunction

  function automatic int llen(input int m, input int y);
    case (m)
      RECT:    return (y >= 50) ? 200 : 1;
      SPARSE:  return (y == 10) ? 20 : 1;
      CORNER:  return (y == 479) ? 640 : 1;
      OVL:     return (y == 50 || y == 60 || y == 100) ? 200 : 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit is_hit(input int m, input int x, input int y);
    case (m)
      RECT:    return x >= 100 && x <= 199 && y >= 50 && y <= 149;
      SPARSE:  return y == 10 && x >= 5 && x <= 14;
      CORNER:  return (x == 0 && y == 0) || (x == 639 && y == 479);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int m, input int y);
    int n = llen(m, y);
    for (int x = 0; x < n; x++) begin
      step();
      if (x == rst_x + 10 && y == rst_y) rst_n = 1'b1;
      vga_de  = 1'b1;
      cur_x   = x;
      cur_y   = y;
      pix_hit = is_hit(m, x, y);
`ifdef BOX_OVERLAY_EN
      rgb_in = in_ovl ? 16'h07E0 : 16'((x * 37 + y * 5 + 1) & 16'hFFFF);
`endif
      if (pix_hit) model_hit(x, y);
      if (x == rst_x && y == rst_y) begin
        #2 rst_n = 1'b0;
        model_reset();
      end
    end
    step();
    vga_de  = 1'b0;
    pix_hit = 1'b0;
    step();
  endtask

  task automatic frame(input int m, input int nl);
    for (int y = 0; y < nl; y++) line(m, y);
  endtask

  task automatic vs_fall();
    step();
    vga_vs = 1'b0;
    step();
    if (m_started) begin
      for (int i = 0; i < 2; i++) begin
        e_upd[i] = 1'b1;
        e_hc[i]  = 20'((m_cnt > 1048575) ? 1048575 : m_cnt);
        e_val[i] = (m_cnt >= thr[i]);
        if (m_cnt >= thr[i]) begin
          e_xmin[i] = 11'(m_xmin); e_xmax[i] = 11'(m_xmax);
          e_ymin[i] = 11'(m_ymin); e_ymax[i] = 11'(m_ymax);
        end
      end
    end else begin
      m_started = 1;
    end
    model_clear();
    step();
    e_upd[0] = 1'b0;
    e_upd[1] = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
    step();
  endtask

  task automatic pin_box(input string nm, input int i, input int x0,
                         input int x1, input int y0, input int y1,
                         input int n, input int v, input int p);
    chk({nm, "_xmin"}, i, 32'(bxmin[i]), x0);
    chk({nm, "_xmax"}, i, 32'(bxmax[i]), x1);
    chk({nm, "_ymin"}, i, 32'(bymin[i]), y0);
    chk({nm, "_ymax"}, i, 32'(bymax[i]), y1);
    chk({nm, "_cnt"},  i, 32'(hc[i]), n);
    chk({nm, "_valid"}, i, 32'(bval[i]), v);
    chk({nm, "_pulses"}, i, pulses[i], p);
  endtask

`ifdef BOX_OVERLAY_EN
  function automatic bit border(input int i, input int x, input int y);
    int x0 = int'(e_xmin[i]), x1 = int'(e_xmax[i]);
    int y0 = int'(e_ymin[i]), y1 = int'(e_ymax[i]);
    return ((x == x0 || x == x1) && y >= y0 && y <= y1)
        || ((y == y0 || y == y1) && x >= x0 && x <= x1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rgb[0] <= '0;
      e_rgb[1] <= '0;
      p_de     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++)
        e_rgb[i] <= (e_val[i] && vga_de && border(i, cur_x, cur_y))
                    ? 16'hF800 : rgb_in;
      p_x  <= cur_x;
      p_y  <= cur_y;
      p_de <= vga_de;
    end
  end
`endif

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("x_min", i, 32'(bxmin[i]), 32'(e_xmin[i]));
      chk("x_max", i, 32'(bxmax[i]), 32'(e_xmax[i]));
      chk("y_min", i, 32'(bymin[i]), 32'(e_ymin[i]));
      chk("y_max", i, 32'(bymax[i]), 32'(e_ymax[i]));
      chk("hit_cnt", i, 32'(hc[i]), 32'(e_hc[i]));
      chk("valid", i, 32'(bval[i]), 32'(e_val[i]));
      chk("update", i, 32'(bupd[i]), 32'(e_upd[i]));
      if (bupd[i] === 1'b1) pulses[i]++;
`ifdef BOX_OVERLAY_EN
      chk("rgb_out", i, 32'(rgb_out[i]), 32'(e_rgb[i]));
      if (in_ovl && p_de) begin
        if (p_x == 100 && p_y == 60) chk("ovl_100_60", i, 32'(rgb_out[i]), 32'hF800);
        if (p_x == 150 && p_y == 50) chk("ovl_150_50", i, 32'(rgb_out[i]), 32'hF800);
        if (p_x == 150 && p_y == 100) chk("ovl_150_100", i, 32'(rgb_out[i]), 32'h07E0);
        if (p_x == 99 && p_y == 60) chk("ovl_99_60", i, 32'(rgb_out[i]), 32'h07E0);
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0; vga_vs = 1'b1; vga_de = 1'b0; pix_hit = 1'b0;
`ifdef BOX_OVERLAY_EN
    rgb_in = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    pin_box("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    vs_fall();
    chk("first_vs_pulses", 0, pulses[0], 0);
    frame(RECT, 60);
    vs_fall();
    pin_box("pre", 0, 100, 199, 50, 59, 1000, 1, 1);
    rst_x = 120; rst_y = 50;
    frame(RECT, 56);
    rst_x = -1; rst_y = -1;
    pin_box("midrst", 0, 0, 0, 0, 0, 0, 0, 1);
    pin_box("midrst", 1, 0, 0, 0, 0, 0, 0, 1);
    vs_fall();
    chk("post_rst_vs_pulses", 0, pulses[0], 1);
    frame(RECT, 150);
    vs_fall();
    pin_box("rect", 0, 100, 199, 50, 149, 10000, 1, 2);
    frame(SPARSE, 21);
    vs_fall();
    pin_box("sparse", 0, 100, 199, 50, 149, 10, 0, 3);
    pin_box("sparse", 1, 5, 14, 10, 10, 10, 1, 3);
    frame(CORNER, 480);
    vs_fall();
    pin_box("corner", 1, 0, 639, 0, 479, 2, 1, 4);
    pin_box("corner", 0, 100, 199, 50, 149, 2, 0, 4);
    frame(NONE, 5);
    vs_fall();
    pin_box("empty", 0, 100, 199, 50, 149, 0, 0, 5);
    pin_box("empty", 1, 0, 639, 0, 479, 0, 0, 5);
    frame(RECT, 150);
    vs_fall();
    pin_box("rect2", 0, 100, 199, 50, 149, 10000, 1, 6);
    in_ovl = 1;
    frame(OVL, 101);
    in_ovl = 0;
    vs_fall();
    pin_box("ovl_frame", 0, 100, 199, 50, 149, 0, 0, 7);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_box_tracker.md
Name: color_box_tracker

Overview:
Downstream consumer of the VGA driver's HSV colour-filtered pixel stream. Rebuilds pixel coordinates from vertical sync and display enable. Accumulates, per frame, the bounding box and count of pixels flagged as colour hits. Publishes the result at each frame boundary for target tracking or on-screen marking.

Parameters:
COORD_W, 11, width of the coordinate counters and box outputs
CNT_W, 20, width of the hit counter (holds 640x480 = 307200)
MIN_HITS, 64, minimum hits per frame for the box to be declared valid
BOX_COLOR, 16'hF800, RGB565 border colour (used only with the optional feature)

Ports:
vga_clk  in  1  pixel clock, shared with the VGA driver
sys_rst_n  in  1  asynchronous active-low reset
vga_vs  in  1  vertical sync, active low
vga_de  in  1  display enable, high during active pixels
pix_hit  in  1  colour-match flag for the current pixel, qualified by vga_de
box_x_min  out  COORD_W  left edge of the last valid box
box_x_max  out  COORD_W  right edge of the last valid box
box_y_min  out  COORD_W  top edge of the last valid box
box_y_max  out  COORD_W  bottom edge of the last valid box
hit_cnt  out  CNT_W  hit count of the last completed frame
box_valid  out  1  last completed frame had hit_cnt >= MIN_HITS
box_update  out  1  one-cycle pulse when outputs are refreshed

Behaviour:
- Reset: asynchronous, active-low. Clears all outputs, all counters and the started flag; accumulators go to their empty values. Applies equally mid-frame.
- Edge detection: vga_vs and vga_de are registered once.
  - frame_start = vs_d & ~vga_vs.
  - line_end = de_d & ~vga_de.
- x_cnt: 0 while vga_de is low; +1 each cycle vga_de is high; value 0 at the first active pixel. Saturates at all-ones.
- y_cnt: cleared on frame_start; +1 on line_end; value 0 for the first active line. Saturates at all-ones.
- Hit: vga_de & pix_hit at coordinate (x_cnt, y_cnt). Per hit:
  - acc_x_min = min(acc_x_min, x); acc_x_max = max(acc_x_max, x); same for y.
  - acc_cnt + 1, saturating at 2^CNT_W-1.
- Empty accumulator: x_min = y_min = all-ones; x_max = y_max = 0; cnt = 0.
- Frame publish, on the cycle after frame_start is detected (one-cycle latency):
  - started = 0: set started; no box_update pulse; outputs unchanged. The partial frame after reset is discarded.
  - started = 1: box_update = 1 for exactly one cycle; hit_cnt <= acc_cnt.
    - If acc_cnt >= MIN_HITS: box_* <= acc_*, box_valid <= 1.
    - Otherwise: box_valid <= 0 and box_* hold their previous values.
  - The accumulator clears in the same cycle the snapshot is taken.
- Simultaneous frame_start and hit (not legal VGA timing): frame_start wins. The hit is dropped and the accumulator is cleared.
- vga_de high while vga_vs is low: still counted; no filtering on sync.
- Outputs are registered and stable between box_update pulses.

Optional Feature:
Macro BOX_OVERLAY_EN.
- Defined: adds ports rgb_in (in, 16, filtered pixel from the VGA driver) and rgb_out (out, 16).
- rgb_out is registered, with 1-cycle latency versus rgb_in, vga_de, x_cnt and y_cnt. It equals BOX_COLOR when all of the following hold:
  - box_valid = 1;
  - vga_de = 1;
  - the pixel lies on the border of the current box: (x == box_x_min or x == box_x_max) with y in [box_y_min, box_y_max], or (y == box_y_min or y == box_y_max) with x in [box_x_min, box_x_max].
- Otherwise rgb_out equals rgb_in. rgb_out resets to 0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-frame, then release: all outputs 0 and box_valid 0. The first vs falling edge gives no box_update; the second gives one pulse.
- Rectangular target, 640x480 frame, MIN_HITS = 64, hits at x 100..199, y 50..149: at the next frame start, box_update pulses one cycle and x_min = 100, x_max = 199, y_min = 50, y_max = 149, hit_cnt = 10000, box_valid = 1.
- Sparse frame following that one, 10 hits: box_valid = 0, hit_cnt = 10, box_* still 100/199/50/149.
- Corner hits, MIN_HITS = 1, hits only at (0,0) and (639,479): box 0..639 by 0..479, hit_cnt = 2, box_valid = 1.
- Empty frame: hit_cnt = 0, box_valid = 0, one box_update pulse, no X or garbage on any output.
- BOX_OVERLAY_EN with valid box 100..199/50..149, rgb_in = 16'h07E0:
  - (100,60) and (150,50): rgb_out = 16'hF800, one cycle after the pixel.
  - (150,100) and (99,60): rgb_out = 16'h07E0.
